// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between a register master and axi4_lite_reg_slave.
// Carries the AW, W, B, AR and R channels.
// The slave modport receives the requests and drives the READY/response side.
// The master modport is the mirror image of the slave modport.
interface axi4_lite_reg_slave_if #(
  parameter int unsigned ADDRESS    = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDRESS-1:0]      S_AWADDR;
  logic                    S_AWVALID;
  logic                    S_AWREADY;
  logic [DATA_WIDTH-1:0]   S_WDATA;
  logic [DATA_WIDTH/8-1:0] S_WSTRB;
  logic                    S_WVALID;
  logic                    S_WREADY;
  logic [1:0]              S_BRESP;
  logic                    S_BVALID;
  logic                    S_BREADY;
  logic [ADDRESS-1:0]      S_ARADDR;
  logic                    S_ARVALID;
  logic                    S_ARREADY;
  logic [DATA_WIDTH-1:0]   S_RDATA;
  logic [1:0]              S_RRESP;
  logic                    S_RVALID;
  logic                    S_RREADY;

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
           S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
           S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register target.
// It holds a bank of NUM_REGS 32-bit registers.
// AW and W are accepted independently and held until both are present. The
// write then commits with byte strobes and a B response. At most one write
// and one read are in flight at a time.
// Out-of-range accesses return SLVERR: writes are dropped and reads return 0.
// Ports:
//   ACLK     - clock, rising edge
//   ARESETN  - synchronous active-low reset
//   s        - AXI4-Lite slave modport (AW/W/B/AR/R channels)
module axi4_lite_reg_slave #(
  parameter int unsigned ADDRESS    = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input logic                  ACLK,
  input logic                  ARESETN,
  axi4_lite_reg_slave_if.slave s
);
  localparam int unsigned        IDXW  = $clog2(NUM_REGS);
  localparam int unsigned        NB    = DATA_WIDTH / 8;
  localparam logic [ADDRESS-1:0] LIMIT = ADDRESS'(4 * NUM_REGS);

  typedef enum logic [1:0] {W_IDLE, W_HOLD, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_RESP} rstate_t;

  function automatic logic in_range(input logic [ADDRESS-1:0] a);
    return a < LIMIT;
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Write path state
  wstate_t               wstate;
  logic                  aw_ready, w_ready, b_valid;
  logic [1:0]            b_resp;
  logic                  aw_full, w_full;
  logic [IDXW-1:0]       aw_idx_q;
  logic                  aw_ok_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NB-1:0]         w_strb_q;

  // Read path state
  rstate_t               rstate;
  logic                  ar_ready, r_valid;
  logic [1:0]            r_resp;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  aw_hs, w_hs, ar_hs, commit, cm_ok;
  logic [IDXW-1:0]       cm_idx, ar_idx;
  logic [DATA_WIDTH-1:0] cm_data, cm_mask, merged;
  logic [NB-1:0]         cm_strb;

  // Commit operands come from the holding registers if already captured,
  // otherwise straight from the channel handshaking at this edge.
  always_comb begin
    aw_hs   = aw_ready & s.S_AWVALID;
    w_hs    = w_ready & s.S_WVALID;
    ar_hs   = ar_ready & s.S_ARVALID;
    ar_idx  = s.S_ARADDR[IDXW+1:2];
    cm_idx  = aw_full ? aw_idx_q : s.S_AWADDR[IDXW+1:2];
    cm_ok   = aw_full ? aw_ok_q : in_range(s.S_AWADDR);
    cm_data = w_full ? w_data_q : s.S_WDATA;
    cm_strb = w_full ? w_strb_q : s.S_WSTRB;
    cm_mask = {{8{cm_strb[3]}}, {8{cm_strb[2]}}, {8{cm_strb[1]}}, {8{cm_strb[0]}}};
    merged  = (regs[cm_idx] & ~cm_mask) | (cm_data & cm_mask);
    commit  = (wstate != W_RESP) & (aw_full | aw_hs) & (w_full | w_hs);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      regs     <= '{default: '0};
      wstate   <= W_IDLE;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= '0;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_idx_q <= '0;
      aw_ok_q  <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else begin
      case (wstate)
        W_IDLE, W_HOLD: begin
          // READY rises on the first edge after reset and stays up while a channel has nothing held.
          if (aw_hs) begin
            aw_full  <= 1'b1;
            aw_idx_q <= s.S_AWADDR[IDXW+1:2];
            aw_ok_q  <= in_range(s.S_AWADDR);
            aw_ready <= 1'b0;
          end else if (!aw_full) begin
            aw_ready <= 1'b1;
          end
          if (w_hs) begin
            w_full   <= 1'b1;
            w_data_q <= s.S_WDATA;
            w_strb_q <= s.S_WSTRB;
            w_ready  <= 1'b0;
          end else if (!w_full) begin
            w_ready <= 1'b1;
          end
          if (commit) begin
            if (cm_ok) regs[cm_idx] <= merged;
            b_resp  <= cm_ok ? 2'b00 : 2'b10;
            b_valid <= 1'b1;
            wstate  <= W_RESP;
          end else if (aw_full | aw_hs | w_full | w_hs) begin
            wstate <= W_HOLD;
          end else begin
            wstate <= W_IDLE;
          end
        end
        W_RESP: begin
          if (s.S_BREADY) begin
            b_valid  <= 1'b0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_ready <= 1'b1;
            w_ready  <= 1'b1;
            wstate   <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Reads sample regs before this edge's write NBA, so a same-edge collision sees the old value.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rstate   <= R_IDLE;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_resp   <= '0;
      r_data   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            r_data   <= in_range(s.S_ARADDR) ? regs[ar_idx] : '0;
            r_resp   <= in_range(s.S_ARADDR) ? 2'b00 : 2'b10;
            r_valid  <= 1'b1;
            ar_ready <= 1'b0;
            rstate   <= R_RESP;
          end else begin
            ar_ready <= 1'b1;
          end
        end
        R_RESP: begin
          if (s.S_RREADY) begin
            r_valid  <= 1'b0;
            ar_ready <= 1'b1;
            rstate   <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign s.S_AWREADY = aw_ready;
  assign s.S_WREADY  = w_ready;
  assign s.S_BVALID  = b_valid;
  assign s.S_BRESP   = b_resp;
  assign s.S_ARREADY = ar_ready;
  assign s.S_RVALID  = r_valid;
  assign s.S_RDATA   = r_data;
  assign s.S_RRESP   = r_resp;
endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Self-checking bench for axi4_lite_reg_slave (NUM_REGS = 16).
// A table of directed read/write vectors is applied in a loop. Hand-written
// sequences then cover the multi-cycle cases: W lagging AW, backpressure,
// reset during a write, and a same-edge read/write collision.
module tb_axi4_lite_reg_slave;
  logic ACLK = 1'b0;
  logic ARESETN;
  int   checks = 0;
  int   errors = 0;

  axi4_lite_reg_slave_if #(.ADDRESS(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_reg_slave #(.ADDRESS(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .s       (bus)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or expected read data
    logic [3:0]  strb;
    logic [1:0]  resp;   // expected BRESP or RRESP
  } vec_t;

  vec_t        vecs [14];
  logic [31:0] model [16];

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_ctl"}, {25'd0, bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY,
        bus.S_BVALID, bus.S_RVALID, bus.S_BRESP[0] | bus.S_RRESP[0],
        bus.S_BRESP[1] | bus.S_RRESP[1]}, 32'h0);
    chk({name, "_rdata"}, bus.S_RDATA, 32'h0);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] st, output logic [1:0] resp);
    bit awp, wp, awg, wg;
    int n;
    bus.S_AWADDR = a; bus.S_AWVALID = 1'b1;
    bus.S_WDATA = d; bus.S_WSTRB = st; bus.S_WVALID = 1'b1;
    awp = 1'b1; wp = 1'b1; n = 0;
    while ((awp || wp) && n < 20) begin
      awg = awp && bus.S_AWREADY;
      wg  = wp && bus.S_WREADY;
      step();
      if (awg) begin awp = 1'b0; bus.S_AWVALID = 1'b0; end
      if (wg)  begin wp = 1'b0;  bus.S_WVALID = 1'b0; end
      n++;
    end
    if (awp || wp) begin
      chk("wr_handshake_timeout", 32'd1, 32'd0);
      bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0;
      resp = 2'bxx;
      return;
    end
    chk("wr_bvalid_latency", {31'd0, bus.S_BVALID}, 32'd1);
    resp = bus.S_BRESP;
    bus.S_BREADY = 1'b1;
    step();
    bus.S_BREADY = 1'b0;
    chk("wr_bvalid_clear", {31'd0, bus.S_BVALID}, 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    bus.S_ARADDR = a; bus.S_ARVALID = 1'b1; n = 0;
    while (!bus.S_ARREADY && n < 20) begin step(); n++; end
    if (!bus.S_ARREADY) begin
      chk("rd_arready_timeout", 32'd1, 32'd0);
      bus.S_ARVALID = 1'b0;
      d = 'x; resp = 2'bxx;
      return;
    end
    step();
    bus.S_ARVALID = 1'b0;
    chk("rd_rvalid_latency", {31'd0, bus.S_RVALID}, 32'd1);
    d = bus.S_RDATA; resp = bus.S_RRESP;
    bus.S_RREADY = 1'b1;
    step();
    bus.S_RREADY = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, msk;
    logic [1:0]  rr;

    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 2'b00};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hABCD_1234, 4'hF, 2'b00};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'hABCD_1234, 4'h0, 2'b00};
    vecs[3]  = '{1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 4'h3, 2'b00};
    vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0000_BEEF, 4'h0, 2'b00};
    vecs[5]  = '{1'b1, 32'h0000_003C, 32'hCAFE_F00D, 4'hF, 2'b00};
    vecs[6]  = '{1'b0, 32'h0000_003F, 32'hCAFE_F00D, 4'h0, 2'b00};
    vecs[7]  = '{1'b1, 32'h0000_0018, 32'h1234_5678, 4'h0, 2'b00};
    vecs[8]  = '{1'b0, 32'h0000_0018, 32'h0000_0000, 4'h0, 2'b00};
    vecs[9]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'hF, 2'b10};
    vecs[10] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, 2'b10};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 2'b10};
    vecs[12] = '{1'b1, 32'h0000_0001, 32'h0000_00A5, 4'h1, 2'b00};
    vecs[13] = '{1'b0, 32'h0000_0000, 32'h0000_00A5, 4'h0, 2'b00};
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    ARESETN = 1'b0;
    bus.S_AWADDR = '0; bus.S_AWVALID = 1'b0; bus.S_WDATA = '0; bus.S_WSTRB = '0;
    bus.S_WVALID = 1'b0; bus.S_BREADY = 1'b0; bus.S_ARADDR = '0;
    bus.S_ARVALID = 1'b0; bus.S_RREADY = 1'b0;

    // Reset and release
    for (int i = 0; i < 2; i++) begin
      step();
      chk_reset_outs($sformatf("reset_cycle%0d", i));
    end
    ARESETN = 1'b1;
    step();
    chk("release_readies", {29'd0, bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY}, 32'h7);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rr);
        chk($sformatf("vec%0d_bresp", i), {30'd0, rr}, {30'd0, vecs[i].resp});
        if (vecs[i].addr < 32'h40) begin
          msk = {{8{vecs[i].strb[3]}}, {8{vecs[i].strb[2]}}, {8{vecs[i].strb[1]}}, {8{vecs[i].strb[0]}}};
          model[vecs[i].addr[5:2]] = (model[vecs[i].addr[5:2]] & ~msk) | (vecs[i].data & msk);
        end
      end else begin
        axi_read(vecs[i].addr, rd, rr);
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].data);
        chk($sformatf("vec%0d_rresp", i), {30'd0, rr}, {30'd0, vecs[i].resp});
      end
    end

    // Whole bank, including registers untouched by the out-of-range write
    for (int i = 0; i < 16; i++) begin
      axi_read(32'(i * 4), rd, rr);
      chk($sformatf("sweep_reg%0d", i), rd, model[i]);
    end

    // W lags AW by three cycles, partial strobe
    bus.S_AWADDR = 32'h10; bus.S_AWVALID = 1'b1;
    step();
    bus.S_AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lag_wait%0d", i),
          {29'd0, bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID}, 32'b010);
      step();
    end
    bus.S_WDATA = 32'h1122_3344; bus.S_WSTRB = 4'b0101; bus.S_WVALID = 1'b1;
    step();
    bus.S_WVALID = 1'b0;
    chk("lag_bvalid", {29'd0, bus.S_BVALID, bus.S_BRESP}, 32'b100);
    bus.S_BREADY = 1'b1; step(); bus.S_BREADY = 1'b0;
    axi_read(32'h10, rd, rr);
    chk("lag_rdata", rd, 32'hAB22_1244);

    // Write backpressure with a second AW waiting
    bus.S_AWADDR = 32'h20; bus.S_AWVALID = 1'b1;
    bus.S_WDATA = 32'h0F0F_0F0F; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1'b1;
    step();
    bus.S_WVALID = 1'b0;
    bus.S_AWADDR = 32'h24;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_b%0d", i),
          {27'd0, bus.S_BVALID, bus.S_BRESP, bus.S_AWREADY, bus.S_WREADY}, 32'b10000);
      step();
    end
    bus.S_BREADY = 1'b1; step(); bus.S_BREADY = 1'b0;
    chk("bp_b_release", {30'd0, bus.S_AWREADY, bus.S_BVALID}, 32'b10);
    axi_write(32'h24, 32'h7777_7777, 4'hF, rr);
    chk("bp_second_bresp", {30'd0, rr}, 32'd0);
    axi_read(32'h24, rd, rr);
    chk("bp_second_rdata", rd, 32'h7777_7777);

    // Read backpressure
    bus.S_ARADDR = 32'h20; bus.S_ARVALID = 1'b1;
    step();
    bus.S_ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_r%0d_ctl", i),
          {28'd0, bus.S_RVALID, bus.S_RRESP, bus.S_ARREADY}, 32'b1000);
      chk($sformatf("bp_r%0d_data", i), bus.S_RDATA, 32'h0F0F_0F0F);
      step();
    end
    bus.S_RREADY = 1'b1; step(); bus.S_RREADY = 1'b0;
    chk("bp_r_release", {30'd0, bus.S_ARREADY, bus.S_RVALID}, 32'b10);

    // Reset after AW handshake discards the held address
    bus.S_AWADDR = 32'h04; bus.S_AWVALID = 1'b1;
    step();
    bus.S_AWVALID = 1'b0;
    ARESETN = 1'b0;
    step();
    chk_reset_outs("midreset");
    ARESETN = 1'b1;
    step();
    chk("midreset_readies", {29'd0, bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY}, 32'h7);
    bus.S_WDATA = 32'h9999_9999; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1'b1;
    step();
    bus.S_WVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("midreset_no_b%0d", i), {31'd0, bus.S_BVALID}, 32'd0);
      step();
    end
    bus.S_AWADDR = 32'h04; bus.S_AWVALID = 1'b1;
    step();
    bus.S_AWVALID = 1'b0;
    chk("midreset_b", {29'd0, bus.S_BVALID, bus.S_BRESP}, 32'b100);
    bus.S_BREADY = 1'b1; step(); bus.S_BREADY = 1'b0;
    axi_read(32'h04, rd, rr);
    chk("midreset_rdata", rd, 32'h9999_9999);
    axi_read(32'h10, rd, rr);
    chk("midreset_cleared_reg", rd, 32'h0);

    // Same-edge AR and write commit to 0x08
    bus.S_AWADDR = 32'h08; bus.S_AWVALID = 1'b1;
    bus.S_WDATA = 32'h5A5A_5A5A; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1'b1;
    bus.S_ARADDR = 32'h08; bus.S_ARVALID = 1'b1;
    step();
    bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0; bus.S_ARVALID = 1'b0;
    chk("collide_valids", {28'd0, bus.S_BVALID, bus.S_RVALID, bus.S_BRESP}, 32'b1100);
    chk("collide_old_data", bus.S_RDATA, 32'h0);
    bus.S_BREADY = 1'b1; bus.S_RREADY = 1'b1;
    step();
    bus.S_BREADY = 1'b0; bus.S_RREADY = 1'b0;
    axi_read(32'h08, rd, rr);
    chk("collide_new_data", rd, 32'h5A5A_5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_lite_reg_slave.md
# axi4_lite_reg_slave

AXI4-Lite responder that terminates the write (AW/W/B) and read (AR/R) channels into a bank of `NUM_REGS` 32-bit software-visible registers. It is the register-target end of the `axi4_lite_master_slave_top` subsystem. It accepts AW and W independently, applies byte strobes, returns SLVERR for out-of-range addresses, and holds at most one write and one read in flight.

## Interface
- `ADDRESS`, 32: address width.
- `DATA_WIDTH`, 32: data width; only 32 is supported (4 strobe bits).
- `NUM_REGS`, 16: number of registers; power of 2, from 2 to 256.

Ports (one clock; reset is synchronous and active-low):
- `ACLK` input 1: clock; all logic on rising edge.
- `ARESETN` input 1: synchronous active-low reset.
- `S_AWADDR` input ADDRESS: write address.
- `S_AWVALID` input 1 / `S_AWREADY` output 1: write-address handshake.
- `S_WDATA` input DATA_WIDTH: write data.
- `S_WSTRB` input DATA_WIDTH/8: byte enables.
- `S_WVALID` input 1 / `S_WREADY` output 1: write-data handshake.
- `S_BRESP` output 2: write response (00 = OKAY, 10 = SLVERR).
- `S_BVALID` output 1 / `S_BREADY` input 1: write-response handshake.
- `S_ARADDR` input ADDRESS: read address.
- `S_ARVALID` input 1 / `S_ARREADY` output 1: read-address handshake.
- `S_RDATA` output DATA_WIDTH: read data.
- `S_RRESP` output 2: read response.
- `S_RVALID` output 1 / `S_RREADY` input 1: read-data handshake.

## Operation
- **Reset** (`ARESETN` = 0 at an edge): all registers and all outputs go to 0, including the READYs. Any held AW or W is discarded.
- **Address decode**
  - Register index = `addr[log2(NUM_REGS)+1:2]`; `addr[1:0]` is ignored.
  - An address is in range iff `addr < 4*NUM_REGS`.
  - Out-of-range write: no register changes; BRESP = 10.
  - Out-of-range read: RDATA = 0; RRESP = 10.
- **Write path**: three states, IDLE, HOLD and RESP.
  - An AW handshake captures the address into the AW holding register and sets `aw_full`.
  - A W handshake captures data and strobe into the W holding register and sets `w_full`.
  - The first edge at which both holding registers are valid (captured earlier or at that edge) is the commit edge. At the commit edge:
    - each byte lane with its strobe bit set is updated;
    - BRESP is set;
    - BVALID goes to 1.
  - BVALID and BRESP hold until the B handshake. At that edge BVALID goes to 0 and `aw_full` and `w_full` clear.
  - WSTRB = 0000 is a legal no-op write and returns OKAY.
- **Read path**: two states, IDLE and RESP.
  - The AR handshake edge samples the register array, loads RDATA and RRESP, and sets RVALID.
  - RVALID, RDATA and RRESP hold until the R handshake.
- **Independence**: the read and write paths are fully independent. Both may hand-shake in the same cycle.
- **Same-edge read and write**: if a read samples a register at the same edge that a write commits to it, the read returns the pre-write value.

## Timing
- **READY signals are registered.**
  - They go to 1 at the first edge with `ARESETN` = 1.
  - AWREADY goes to 0 the edge after an AW handshake and returns to 1 at the edge of the B handshake.
  - WREADY behaves the same way, with respect to the W handshake.
  - ARREADY goes to 0 the edge after an AR handshake and returns to 1 at the edge of the R handshake.
- **Write latency**: BVALID is asserted 1 cycle after the later of the AW and W handshakes. The register value is readable from that same cycle.
- **Read latency**: RVALID is asserted 1 cycle after the AR handshake.
- **Throughput**: back-to-back writes with BREADY = 1 give one write every 2 cycles. Reads behave the same.
- **Stability**: VALID and payload never change while VALID = 1 and READY = 0. No VALID output depends combinationally on any input.
- **Reset mid-transaction**: the reset takes effect at that edge regardless of state. A W arriving after a discarded AW is held and does not produce a B until a new AW arrives.

## Test plan
1. **Reset and release**
   - Stimulus: ARESETN low for 2 cycles, then high.
   - Required: all outputs are 0 during reset; AWREADY, WREADY and ARREADY are 1 one cycle after release.
   - Then read 0x00: RDATA = 0x00000000, RRESP = 00.
2. **Full write, then read**
   - Stimulus: AW = 0x10 and W = 0xABCD1234 (WSTRB 1111) handshake in the same cycle.
   - Required: BVALID = 1 the next cycle with BRESP = 00.
   - Then read 0x10: RVALID 1 cycle after AR, RDATA = 0xABCD1234, RRESP = 00.
3. **Partial write with W lagging AW**
   - Stimulus: AW = 0x10; W = 0x11223344 with WSTRB 0101 arrives 3 cycles later.
   - Required: WREADY stays 1 and AWREADY is 0 while waiting; BVALID is asserted 1 cycle after the W handshake.
   - Then read 0x10: RDATA = 0xAB221244.
4. **Backpressure**
   - Stimulus: BREADY held low for 5 cycles after a write; RREADY held low for 5 cycles after a read.
   - Required: BVALID/BRESP and RVALID/RDATA stay stable throughout. AWREADY, WREADY and ARREADY stay 0, and a second AW is not accepted until the B handshake.
5. **Out-of-range access** (NUM_REGS = 16)
   - Write 0x40 = 0xFFFFFFFF: BRESP = 10, and all 16 registers are unchanged.
   - Read 0x40: RDATA = 0, RRESP = 10.
6. **Reset mid-write and same-edge collision**
   - Reset case: after an AW handshake to 0x04, pulse ARESETN low for 1 cycle. Then issue a W only: no BVALID appears. Then issue AW 0x04: B arrives with BRESP = 00.
   - Collision case: an AR to 0x08 and a commit to 0x08 (value 0x5A5A5A5A) fall on the same edge. The read returns the old value 0x00000000; a subsequent read returns 0x5A5A5A5A.
